// File: rtl/gearbox_pkg.sv
// Shared definitions for the 66:64 transmit gearbox: sequence counter width,
// period length and the counter type used by the top and every lane.
package gearbox_pkg;

  localparam int SEQ_W    = 6;
  localparam int SEQ_LAST = 32;

  typedef logic [SEQ_W-1:0] seq_t;

endpackage

// File: rtl/gearbox_lane_tx.sv
// One lane of the 66:64 transmit gearbox: residual register plus registered
// 64-bit output word, stepped by the shared sequence counter.
module gearbox_lane_tx
  import gearbox_pkg::*;
#(
  parameter int HEAD_W  = 2,
  parameter int DATA_W  = 64,
  parameter int BLOCK_W = HEAD_W + DATA_W
) (
  input  logic               clk,
  input  logic               nreset,
  input  seq_t               seq,
  input  logic [BLOCK_W-1:0] block_i,
  output logic [DATA_W-1:0]  data_o
);

  localparam int WIDE_W = 2 * DATA_W;

  logic [DATA_W-1:0] res_q;
  logic [WIDE_W-1:0] shifted;
  logic [WIDE_W-1:0] comb;

  // Residual length is always HEAD_W*seq, so each accept cycle is one of a
  // fixed set of constant shifts selected by seq; res_q bits above the
  // valid length are always zero, so OR-ing merges block and residual.
  always_comb begin
    shifted = '0;
    for (int k = 0; k < SEQ_LAST; k++) begin
      if (seq == seq_t'(k)) begin
        shifted = {{(WIDE_W - BLOCK_W){1'b0}}, block_i} << (HEAD_W * k);
      end
    end
    comb = shifted | {{(WIDE_W - DATA_W){1'b0}}, res_q};
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      res_q  <= '0;
      data_o <= '0;
    end else if (seq == seq_t'(SEQ_LAST)) begin
      data_o <= res_q;
      res_q  <= '0;
    end else begin
      data_o <= comb[DATA_W-1:0];
      res_q  <= comb[WIDE_W-1:DATA_W];
    end
  end

endmodule

// File: rtl/gearbox_tx.sv
// Multi-lane 66:64 transmit gearbox: owns the shared 33-cycle sequence and
// the upstream ready, and fans out one gearbox_lane_tx per PCS lane.
module gearbox_tx
  import gearbox_pkg::*;
#(
  parameter int LANE_N  = 4,
  parameter int HEAD_W  = 2,
  parameter int DATA_W  = 64,
  parameter int BLOCK_W = HEAD_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic [LANE_N*DATA_W-1:0] data_o
);

  seq_t seq_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      seq_q <= '0;
    end else if (seq_q == seq_t'(SEQ_LAST)) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_q + seq_t'(1);
    end
  end

  // Upstream stalls during the flush slot of every period.
  assign ready_o = (seq_q != seq_t'(SEQ_LAST)) & nreset;

  for (genvar g = 0; g < LANE_N; g++) begin : g_lane
    gearbox_lane_tx #(
      .HEAD_W (HEAD_W),
      .DATA_W (DATA_W),
      .BLOCK_W(BLOCK_W)
    ) u_lane (
      .clk    (clk),
      .nreset (nreset),
      .seq    (seq_q),
      .block_i({data_i[g*DATA_W +: DATA_W], head_i[g*HEAD_W +: HEAD_W]}),
      .data_o (data_o[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_gearbox_tx.sv
// Directed bench for gearbox_tx: reset, first word, stall period, per-lane
// bitstream reconstruction, mid-period reset and lane independence.
module tb_gearbox_tx;

  localparam int LANE_N  = 4;
  localparam int HEAD_W  = 2;
  localparam int DATA_W  = 64;
  localparam int BLOCK_W = HEAD_W + DATA_W;

  logic                     clk = 1'b0;
  logic                     nreset;
  logic [LANE_N*HEAD_W-1:0] head_i;
  logic [LANE_N*DATA_W-1:0] data_i;
  logic                     ready_o;
  logic [LANE_N*DATA_W-1:0] data_o;

  int checks = 0;
  int errors = 0;
  int c      = 0;

  logic [BLOCK_W-1:0] blk  [LANE_N];
  logic [BLOCK_W-1:0] save [LANE_N];
  logic [191:0]       mbuf [LANE_N];
  int                 mcnt [LANE_N];

  gearbox_tx #(
    .LANE_N (LANE_N),
    .HEAD_W (HEAD_W),
    .DATA_W (DATA_W),
    .BLOCK_W(BLOCK_W)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .head_i (head_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  task automatic drive();
    for (int l = 0; l < LANE_N; l++) begin
      head_i[l*HEAD_W +: HEAD_W] = blk[l][HEAD_W-1:0];
      data_i[l*DATA_W +: DATA_W] = blk[l][BLOCK_W-1:HEAD_W];
    end
  endtask

  task automatic new_blocks(input bit rnd);
    for (int l = 0; l < LANE_N; l++) begin
      if (rnd) blk[l] = BLOCK_W'({$urandom(), $urandom(), $urandom()});
      else     blk[l] = {{16{4'(l)}}, 2'b10};
    end
  endtask

  // Append the presented blocks LSB-first to each lane's expected bitstream.
  task automatic push();
    for (int l = 0; l < LANE_N; l++) begin
      mbuf[l] = mbuf[l] | ({126'b0, blk[l]} << mcnt[l]);
      mcnt[l] = mcnt[l] + BLOCK_W;
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < LANE_N; l++) begin
      mbuf[l] = '0;
      mcnt[l] = 0;
    end
  endtask

  // Called at a negedge: release reset and present the first block (seq 0).
  task automatic release_rst(input bit rnd);
    nreset = 1'b1;
    model_clear();
    c = 0;
    new_blocks(rnd);
    drive();
    #1;
    check("release_ready", 64'(ready_o), 64'd1);
    push();
  endtask

  task automatic step(input bit rnd);
    logic [63:0] w;
    @(negedge clk);
    for (int l = 0; l < LANE_N; l++) begin
      if (mcnt[l] < DATA_W) begin
        check("underflow", 64'(mcnt[l]), 64'(DATA_W));
      end else begin
        w = mbuf[l][63:0];
        mbuf[l] = mbuf[l] >> DATA_W;
        mcnt[l] = mcnt[l] - DATA_W;
        check($sformatf("stream_l%0d", l), data_o[l*DATA_W +: DATA_W], w);
      end
    end
    c++;
    check("ready", 64'(ready_o), 64'((c % 33) != 32));
    if ((c % 33) != 32) begin
      new_blocks(rnd);
      drive();
      push();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(ready_o), 64'd0);
    for (int l = 0; l < LANE_N; l++)
      check($sformatf("%s_data_l%0d", tag, l), data_o[l*DATA_W +: DATA_W], 64'd0);
  endtask

  initial begin
    nreset = 1'b0;
    head_i = '0;
    data_i = '0;
    for (int l = 0; l < LANE_N; l++) blk[l] = '0;
    model_clear();

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("rst");
    end

    // First word: lane0 head=01, data=0 at seq 0
    nreset = 1'b1;
    model_clear();
    c = 0;
    new_blocks(1'b1);
    blk[0] = {64'h0, 2'b01};
    drive();
    #1;
    check("release_ready", 64'(ready_o), 64'd1);
    push();
    step(1'b1);
    check("first_word", data_o[63:0], 64'h1);

    // Free run: stall period and bitstream integrity over 100 periods
    for (int i = 0; i < 100 * 33; i++) step(1'b1);

    // Mid-period reset at seq 17
    while ((c % 33) != 17) step(1'b1);
    nreset = 1'b0;
    #1;
    check("midrst_ready_comb", 64'(ready_o), 64'd0);
    @(negedge clk);
    check_zero("midrst");
    release_rst(1'b1);
    for (int l = 0; l < LANE_N; l++) save[l] = blk[l];
    step(1'b1);
    for (int l = 0; l < LANE_N; l++)
      check($sformatf("post_rst_l%0d", l), data_o[l*DATA_W +: DATA_W], save[l][63:0]);
    for (int i = 0; i < 70; i++) step(1'b1);

    // Lane independence with constant per-lane blocks
    nreset = 1'b0;
    @(negedge clk);
    check_zero("rst2");
    release_rst(1'b0);
    for (int i = 0; i < 2 * 33; i++) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gearbox_tx.md
# gearbox_tx

Multi-lane 66:64 transmit gearbox. It sits directly downstream of the alignment-marker inserter and converts each lane's 66-bit block stream ({data, head}) into a continuous 64-bit-per-cycle word stream for the PMA/SerDes interface. A shared 33-cycle sequence keeps all lanes in lockstep. Upstream must stall one cycle in every 33, signalled by `ready_o`.

## Interface
- `LANE_N`, 4: number of PCS lanes.
- `HEAD_W`, 2: sync header width per block.
- `DATA_W`, 64: block payload width, and also the output word width per lane.
- `BLOCK_W`, `HEAD_W+DATA_W` (66): block width.
- `clk`  in  1: clock.
- `nreset`  in  1: reset, synchronous, active-low.
- `head_i`  in  `LANE_N*HEAD_W`: per-lane sync header; lane i occupies `[i*HEAD_W +: HEAD_W]`.
- `data_i`  in  `LANE_N*DATA_W`: per-lane payload; lane i occupies `[i*DATA_W +: DATA_W]`.
- `ready_o`  out  1: block on `head_i`/`data_i` is consumed this cycle.
- `data_o`  out  `LANE_N*DATA_W`: per-lane 64-bit PMA word, registered; lane i occupies `[i*DATA_W +: DATA_W]`.

## Operation
- **Bit order**
  - Block = {data, head}. Bit 0 is head[0] and is transmitted first.
  - `data_o` bit 0 is transmitted first.
- **Sequence counter**
  - `seq_q` is 6 bits, shared by all lanes, and counts 0..32 then wraps to 0.
  - It increments every cycle when not in reset, with no enable.
  - 32 blocks × 66 = 33 words × 64 = 2112 bits per period.
- **`ready_o`**
  - `ready_o = (seq_q != 32) & nreset`.
  - When `ready_o` is low, upstream must freeze and hold its block. The block is resampled the next cycle.
- **Per-lane residual register**
  - 64 bits, `res_q`, valid length 2·seq_q bits, LSB-aligned.
- **Accept cycle (seq_q = k, 0 ≤ k ≤ 31)**
  - Form comb = {block, res_q[2k-1:0]}, 66+2k bits.
  - `data_o` <= comb[63:0].
  - `res_q` <= comb[65+2k:64], 2k+2 bits, zero-extended.
- **Flush cycle (seq_q = 32)**
  - `data_o` <= `res_q`, which holds exactly 64 valid bits.
  - `res_q` <= 0.
  - Input is ignored.
- **Shift width**
  - Only even residual lengths occur. Implement as a 33-way mux keyed by `seq_q`, not as a generic barrel shifter.
- **Reset (synchronous, any cycle, including mid-period)**
  - `seq_q`=0, `res_q`=0, `data_o`=0, `ready_o`=0.
  - The first cycle after reset release is seq 0: accept, with `ready_o`=1.
- **Lanes**
  - Lanes share nothing except `seq_q` and `ready_o`. No cross-lane bit movement.

## Timing
- `data_o` latency: 1 cycle after the cycle in which its last contributing bit was accepted or flushed.
- `ready_o` is combinational from `seq_q` and `nreset` only, with no input dependency.
- Steady state: `ready_o` is high for 32 cycles, then low for 1, repeating with period 33.
- A new `data_o` word appears every cycle, with no bubbles except the zeros held during reset.
- Wrap: the seq 32 → 0 transition has no idle cycle. The word from seq 0 starts the next period and has no residual bits.

## Structure
- Package `gearbox_pkg`:
  - `SEQ_W`=6.
  - `SEQ_LAST`=32.
  - The `seq_t` typedef.
- Top `gearbox_tx` owns `seq_q` and `ready_o`, and generates `LANE_N` instances of `gearbox_lane_tx`.
- `gearbox_lane_tx` (clk, nreset, seq, block_i[65:0], data_o[63:0]) holds `res_q` and the output register.

## Test plan
- **Reset:** hold `nreset` low for 3 cycles → `data_o`=0 and `ready_o`=0 throughout. On release, `ready_o`=1 and seq=0.
- **First word:** lane0 block head=2'b01, data=0 at seq 0 → next-cycle lane0 `data_o`=64'h1.
- **Period:** free run for 5 periods → `ready_o` low exactly at cycles 32, 65, 98, … after release, high otherwise.
- **Bitstream integrity:** feed a random block stream, where held blocks during stall are not consumed twice. Serialise `data_o` LSB-first and compare with the input blocks serialised LSB-first over 100 periods → identical per lane.
- **Mid-period reset:** assert reset at seq 17 → next cycle all outputs are 0. After release, the first word equals the low 64 bits of the new block, with no stale residual.
- **Lane independence:** lane k carries the constant block {64'hk…k, 2'b10} with distinct values per lane → each lane's reconstructed stream contains only its own pattern.
